dmem_initiator: RTL and testbench
=================================

# dmem_initiator

Load/store initiator that sits between the pipeline memory stage and `data_memory`. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's `address`/`write_data`/`mem_write`/`mem_read` strobes for exactly one cycle. It absorbs the memory's one-cycle registered read latency and returns the result over a second valid/ready handshake. Only one transaction is outstanding at any time.

## Interface
Parameters:
- `ADDR_W`, 64: request and memory address width.
- `DATA_W`, 64: data width.
- `DEPTH_LOG2`, 8: log2 of the memory word count; the memory index is `addr[DEPTH_LOG2-1:0]`.

Ports (clock and reset as decided):
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_W  load data; 0 for stores and errors.
- `rsp_err`  out  1  address error; constant 0 unless the bounds check is compiled in.
- `mem_addr`  out  ADDR_W  to `data_memory.address`.
- `mem_wdata`  out  DATA_W  to `data_memory.write_data`.
- `mem_write`  out  1  to `data_memory.mem_write`.
- `mem_read`  out  1  to `data_memory.mem_read`.
- `mem_rdata`  in  DATA_W  from `data_memory.read_data`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the request is accepted: address, data and type are registered and the FSM moves to ISSUE.
- ISSUE:
  - `mem_read` or `mem_write` is asserted for exactly this one cycle, driven from the registered request.
  - Load: next state is WAIT. Store: next state is RESP.
  - A store is committed to memory at the edge that ends ISSUE.
- WAIT:
  - Strobes are low. `mem_rdata` is valid in this cycle.
  - `mem_rdata` is captured into `rsp_rdata` at the edge that ends WAIT; next state is RESP.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are stable.
  - The FSM stays in RESP until `rsp_ready`=1, then returns to IDLE.
- `req_ready`=0 in every state except IDLE. There is no request buffering and no bypass from RESP to the next request.
- `mem_addr` and `mem_wdata` hold the last issued values outside ISSUE. `mem_write` and `mem_read` are never both 1.
- The response valid/ready rule: `rsp_valid` must not drop and its payload must not change before the handshake completes.
- A request presented while `req_ready`=0 is ignored. The requester must hold it until it is accepted.

## Timing
- The request is accepted at edge E0, and ISSUE is the cycle after E0.
- Store: `rsp_valid` rises 2 cycles after E0.
- Load: `rsp_valid` rises 3 cycles after E0.
- With `rsp_ready` held at 1, the next request can be accepted 3 cycles (store) or 4 cycles (load) after E0.
- Reset values: FSM=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_addr`=0, `mem_wdata`=0, `mem_write`=0, `mem_read`=0.
- Reset asserted mid-transaction: the FSM returns to IDLE and the strobes drop immediately, asynchronously. A store whose ISSUE cycle had not yet completed is dropped. A pending response is lost.

## Configuration
- Macro: `DMEM_BOUNDS_CHECK_EN`.
- Defined:
  - A request with `req_addr[ADDR_W-1:DEPTH_LOG2]` != 0 raises no strobes in ISSUE.
  - The FSM goes straight from ISSUE to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - Latency is the same as for a store.
- Not defined:
  - The upper address bits pass through to `mem_addr` unchanged; the memory uses only the low bits, so the access wraps.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `dmem_pkg` holds:
  - the `dmem_state_t` enum (IDLE, ISSUE, WAIT, RESP);
  - the `DMEM_DEPTH_LOG2`=8 and `DMEM_DATA_W`=64 constants;
  - the status encoding shared with the pipeline stat logic (AOK, ADR).
- No sub-module: a single FSM plus request and response registers is natural.

## Test plan
- Reset then store: store addr 0x10, data 0xDEADBEEF_CAFEF00D -> exactly one `mem_write` pulse with `mem_addr`=0x10; `rsp_valid` 2 cycles after accept with `rsp_err`=0.
- Load after store: load addr 0x10 -> one `mem_read` pulse; `rsp_rdata`=0xDEADBEEF_CAFEF00D, `rsp_valid` 3 cycles after accept.
- Response backpressure: `rsp_ready` held 0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, no extra strobes; release -> IDLE the next cycle.
- Out-of-range address: load addr 0x100.
  - With `DMEM_BOUNDS_CHECK_EN`: no strobes, `rsp_err`=1, `rsp_rdata`=0.
  - Without it: `mem_addr`=0x100 with `mem_read` pulsed; the response is the word at index 0x00.
- Back-to-back: 8 alternating stores/loads to addresses 0xFF down to 0xF8 with `rsp_ready`=1 -> each load returns its store data; the two strobes are never asserted together.
- Reset mid-load: deassert `rst_n` during WAIT -> all outputs return to reset values at once; after release, the next request completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory initiator and the pipeline
// status logic.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  localparam int DMEM_DEPTH_LOG2 = 8;
  localparam int DMEM_DATA_W     = 64;

  // Status encoding shared with the pipeline stat logic
  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_ADR = 2'd1
  } dmem_stat_t;

endpackage

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store initiator in front of data_memory.
// Optional bounds check on the request address: DMEM_BOUNDS_CHECK_EN.
module dmem_initiator
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 >= ADDR_W) begin : g_param_check
    $error("dmem_initiator: DEPTH_LOG2 must lie in [1, ADDR_W-1]");
  end

  dmem_state_t       state_r;
  dmem_state_t       next_s;
  dmem_stat_t        acc_stat_s;
  logic              acc_s;
  logic              req_write_r;
  logic              req_err_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_write_r;
  logic              mem_read_r;

  assign acc_s = (state_r == IDLE) && req_valid;

  // Classify the incoming request address
  always_comb begin
    acc_stat_s = STAT_AOK;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (req_addr[ADDR_W-1:DEPTH_LOG2] != {(ADDR_W-DEPTH_LOG2){1'b0}}) begin
      acc_stat_s = STAT_ADR;
    end else begin
      acc_stat_s = STAT_AOK;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (req_valid) next_s = ISSUE; else next_s = IDLE;
      // Stores and rejected requests have no read data to wait for
      ISSUE:   if (req_write_r || req_err_r) next_s = RESP; else next_s = WAIT;
      WAIT:    next_s = RESP;
      RESP:    if (rsp_ready) next_s = IDLE; else next_s = RESP;
      default: next_s = IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      req_ready_r <= (next_s == IDLE);
      rsp_valid_r <= (next_s == RESP);
    end
  end

  // Request capture, one-cycle memory strobes and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_write_r <= 1'b0;
      req_err_r   <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
    end else begin
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      if (acc_s) begin
        req_write_r <= req_write;
        req_err_r   <= (acc_stat_s == STAT_ADR);
        rsp_err_r   <= (acc_stat_s == STAT_ADR);
        rsp_rdata_r <= {DATA_W{1'b0}};
        // A rejected address never reaches the memory pins
        if (acc_stat_s == STAT_AOK) begin
          mem_addr_r  <= req_addr;
          mem_wdata_r <= req_wdata;
          mem_write_r <= req_write;
          mem_read_r  <= !req_write;
        end
      end
      if (state_r == WAIT) begin
        rsp_rdata_r <= mem_rdata;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_write = mem_write_r;
  assign mem_read  = mem_read_r;

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator with a behavioural data_memory and a
// word-array reference model.
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata = 64'd0;

  dmem_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data_memory: synchronous write, registered read
  logic [63:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    logic        strobes;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          rr_mode = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: always, random, or held off
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: strobe and response checks against the scoreboard head
  int   neg_idx = 0;
  int   acc_idx = 0;
  bit   acc_seen = 0;
  bit   in_rsp = 0;
  bit   expect_idle = 0;
  int   strobe_cnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    neg_idx++;
    if (!rst_n) begin
      acc_seen = 0; in_rsp = 0; expect_idle = 0; strobe_cnt = 0;
    end else begin
      chk(!(mem_write && mem_read), "strobe_exclusive", {62'd0, mem_write, mem_read}, 64'd0);
      if (expect_idle) begin
        chk(req_ready && !rsp_valid, "idle_after_rsp", {62'd0, req_ready, rsp_valid}, 64'd2);
        expect_idle = 0;
      end
      if (mem_write || mem_read) begin
        if (sb_q.size() == 0 || !acc_seen) begin
          chk(0, "stray_strobe", {62'd0, mem_write, mem_read}, 64'd0);
        end else begin
          cur = sb_q[0];
          strobe_cnt++;
          chk(neg_idx - acc_idx == 1, "strobe_cycle", 64'(neg_idx - acc_idx), 64'd1);
          chk(mem_write == cur.wr && mem_read == !cur.wr, "strobe_kind", {62'd0, mem_write, mem_read}, {62'd0, cur.wr, !cur.wr});
          chk(mem_addr == cur.addr, "mem_addr", mem_addr, cur.addr);
          if (cur.wr) chk(mem_wdata == cur.wdata, "mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk(0, "unexpected_rsp", rsp_rdata, 64'd0);
        end else begin
          cur = sb_q[0];
          if (!in_rsp) begin
            chk(neg_idx - acc_idx == ((cur.wr || cur.err) ? 2 : 3), "rsp_latency",
                64'(neg_idx - acc_idx), ((cur.wr || cur.err) ? 64'd2 : 64'd3));
            chk(strobe_cnt == int'(cur.strobes), "strobe_count", 64'(strobe_cnt), {63'd0, cur.strobes});
          end
          chk(rsp_rdata == cur.rdata, "rsp_rdata", rsp_rdata, cur.rdata);
          chk(rsp_err == cur.err, "rsp_err", {63'd0, rsp_err}, {63'd0, cur.err});
          chk(!req_ready, "req_ready_in_rsp", {63'd0, req_ready}, 64'd0);
          in_rsp = 1;
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            in_rsp = 0; acc_seen = 0; expect_idle = 1;
          end
        end
      end
      if (req_valid && req_ready) begin
        acc_idx = neg_idx; acc_seen = 1; strobe_cnt = 0;
      end
    end
  end

  // Present a request, wait for acceptance, record its expected outcome
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
    exp_t e;
    bit   ok = 0;
    bit   bad = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      chk(0, "accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
`ifdef DMEM_BOUNDS_CHECK_EN
    bad = (addr >> 8) != 64'd0;
`endif
    e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.err = bad; e.strobes = !bad; e.rdata = 64'd0;
    if (!bad) begin
      if (wr) ref_mem[addr[7:0]] = wdata;
      else    e.rdata = ref_mem[addr[7:0]];
    end
    sb_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !rsp_valid) done = 1;
    end
    if (!done) begin
      chk(0, "drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk(req_ready == 1'b1, {tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk(rsp_valid == 1'b0, {tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk(rsp_rdata == 64'd0, {tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk(rsp_err == 1'b0, {tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    chk(mem_addr == 64'd0, {tag, "_mem_addr"}, mem_addr, 64'd0);
    chk(mem_wdata == 64'd0, {tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk(mem_write == 1'b0, {tag, "_mem_write"}, {63'd0, mem_write}, 64'd0);
    chk(mem_read == 1'b0, {tag, "_mem_read"}, {63'd0, mem_read}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 64'd0;
      ref_mem[i] = 64'd0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_checks("reset");
    rst_n = 1'b1;

    // Directed: store then load at 0x10
    do_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
    wait_drain();
    do_req(1'b0, 64'h10, 64'd0);
    wait_drain();

    // Response backpressure for 5 cycles
    rr_mode = 2;
    do_req(1'b0, 64'h10, 64'd0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    chk(ok, "bp_rsp_seen", {63'd0, ok}, 64'd1);
    repeat (5) @(negedge clk);
    rr_mode = 0;
    wait_drain();

    // Out-of-range load wraps (or is rejected when bounds checking is built)
    do_req(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF);
    wait_drain();
    do_req(1'b0, 64'h100, 64'd0);
    wait_drain();

    // Back-to-back store/load pairs with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      a = 64'hFF - 64'(i);
      do_req(1'b1, a, {$urandom, $urandom});
      do_req(1'b0, a, 64'd0);
    end
    wait_drain();

    // Random traffic with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
      do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    wait_drain();
    rr_mode = 0;

    // Reset while the load sits in WAIT
    do_req(1'b0, 64'h20, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 reset_checks("midreset");
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(1'b0, 64'h10, 64'd0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
